// File: rtl/syn_counter_checker.sv
// Read-side monitor for a free-running up/down counter: predicts each sample from
// the previous one and the previously sampled direction, and reports lock, errors and wraps.
module syn_counter_checker #(
   parameter int WIDTH      = 3,
   parameter int ERR_CNT_W  = 4,
   parameter int RESYNC_LEN = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     count,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 wrap,
   output logic                 dir_chg,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0]     ALL_ONES = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
   localparam logic [2:0]           RESYNC   = 3'(RESYNC_LEN);

   state_t           state;
   logic [WIDTH-1:0] prev_count;
   logic             mode_q;
   logic [2:0]       good_cnt;
   logic [WIDTH-1:0] expected;
   logic             step_ok;
   logic             wrap_hit;

   // The value seen now was produced with the direction sampled one edge ago.
   always_comb begin
      expected = mode_q ? prev_count + ONE : prev_count - ONE;
      step_ok  = (count == expected);
      wrap_hit = mode_q ? (prev_count == ALL_ONES && count == '0)
                        : (prev_count == '0 && count == ALL_ONES);
   end

   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         prev_count <= '0;
         mode_q     <= 1'b0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
         wrap       <= 1'b0;
         dir_chg    <= 1'b0;
      end else begin
         prev_count <= count;
         mode_q     <= mode;
         err        <= 1'b0;
         wrap       <= 1'b0;
         dir_chg    <= 1'b0;
         case (state)
            INIT: begin
               state    <= SYNC;
               good_cnt <= '0;
            end
            SYNC: begin
               dir_chg <= (mode != mode_q);
               if (step_ok) begin
                  good_cnt <= good_cnt + 3'd1;
                  if (good_cnt + 3'd1 == RESYNC) begin
                     state  <= LOCK;
                     locked <= 1'b1;
                  end
               end else begin
                  good_cnt <= '0;
               end
            end
            LOCK: begin
               dir_chg <= (mode != mode_q);
               if (step_ok) begin
                  wrap <= wrap_hit;
               end else begin
                  err      <= 1'b1;
                  locked   <= 1'b0;
                  state    <= SYNC;
                  good_cnt <= '0;
                  if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
               end
            end
            default: begin
               state    <= INIT;
               locked   <= 1'b0;
               good_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/syn_counter_checker.md
Name: syn_counter_checker

Overview:
- Read-side companion to the 3-bit synchronous up/down counter.
- Samples the counter's output and its `mode` every clock, predicts the next value and confirms the stream follows a legal sequence.
- Reports lock, step errors, wrap-arounds and direction changes.
- Used as an in-design monitor and as a self-checking element in counter benches.

Parameters:
- WIDTH, 3, width of the count bus being checked
- ERR_CNT_W, 4, width of the saturating error counter
- RESYNC_LEN, 2, consecutive correct steps required to (re)acquire lock; legal range 1..7

Ports:
- clk  input  1  rising-edge clock, same clock as the checked counter
- reset  input  1  asynchronous, active-low reset (0 = reset)
- mode  input  1  direction of the checked counter: 1 = up, 0 = down
- count  input  WIDTH  counter output being checked
- locked  output  1  high while the sequence is tracked correctly
- err  output  1  one-cycle pulse: illegal step while locked
- err_count  output  ERR_CNT_W  number of errors, saturating at all-ones
- wrap  output  1  one-cycle pulse: legal wrap-around while locked
- dir_chg  output  1  one-cycle pulse: mode differs from previous sample

Behaviour:

Reset (reset = 0, asynchronous, takes effect immediately without a clock edge):
- state = INIT; prev_count = 0; mode_q = 0; good_cnt = 0.
- All outputs 0.
- Reset asserted mid-operation discards lock and err_count.

Internal registers:
- prev_count: WIDTH, the count sampled at the previous edge.
- mode_q: the mode sampled at the previous edge.
- good_cnt: 3-bit count of consecutive correct steps.

Prediction:
- expected = prev_count + 1 mod 2^WIDTH if mode_q = 1; prev_count − 1 mod 2^WIDTH if mode_q = 0.
- Rationale: the counter's value at edge k was produced with mode as sampled at edge k−1.
- step_ok = (count == expected).
- A held value (count == prev_count) is an error, because the counter has no enable.

Every edge: prev_count <= count; mode_q <= mode.

State machine (2-bit, registered), one step per rising clk edge:
- INIT: first edge after reset release only captures prev_count and mode_q. Go to SYNC, good_cnt = 0. No outputs pulse.
- SYNC:
  - step_ok → good_cnt + 1. If this reaches RESYNC_LEN, go to LOCK and set locked = 1 on the same edge.
  - Otherwise → good_cnt = 0, stay in SYNC.
  - err never pulses in SYNC.
- LOCK:
  - step_ok → stay in LOCK.
  - Otherwise → err = 1 for one cycle, err_count + 1 (saturating), locked = 0, go to SYNC, good_cnt = 0.

Registered outputs (1-edge latency): err, wrap, dir_chg and locked update on the same edge at which count is compared. They are visible until the next edge.
- wrap = 1 in LOCK with step_ok and either:
  - mode_q = 1, prev_count = all-ones, count = 0; or
  - mode_q = 0, prev_count = 0, count = all-ones.
- wrap never pulses together with err.
- dir_chg = (mode != mode_q); valid in all states except INIT.
- A mode change does not by itself break lock; the step after the change is checked in the new direction.
- err_count holds at 2^ERR_CNT_W − 1 once saturated. It is cleared only by reset.

Test Plan:
- Reset sequencing: clk period 2; reset 1→0 at t=1, 0→1 at t=2; counter counting up → all outputs 0 while reset = 0; locked rises on the 3rd edge after release (INIT + 2 good steps); err_count = 0.
- Up wrap: locked, mode = 1, count 6→7→0 → single wrap pulse on the 7→0 edge; err stays 0.
- Direction change: mode 1→0 while count = 3 → dir_chg pulses once; locked stays 1; later 1→0→7 gives a wrap pulse on the 0→7 edge.
- Glitch injection: force count 3→5 while locked, mode = 1 → err pulse one cycle; err_count = 1; locked = 0; locked returns to 1 after 2 further correct steps.
- Stuck counter: hold count = 4 for 40 cycles after lock → exactly 1 err pulse; locked stays 0 with no further err; err_count = 1.
- Saturation and mid-run reset: inject 20 errors, relocking between each → err_count = 15; then pull reset low between edges → locked = 0 and err_count = 0 immediately, before the next clk edge.
